// File: rtl/riscv_imem_pkg.sv
// ============================================================================
// riscv_imem_pkg -- shared types/constants for the instruction RAM controller
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_imem_pkg;

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   // True when the byte address lies outside the RAM or is not word aligned.
   function automatic logic addr_oob(input logic [31:0] addr, input int unsigned aw);
      return ((addr >> (aw + 2)) != 32'd0) || (addr[1:0] != 2'b00);
   endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_imem_sram.sv
// ============================================================================
// riscv_imem_sram -- single-port synchronous RAM, DEPTH x 32, registered read
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_imem_sram
   import riscv_imem_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];

   // Read port only updates on a read so the last fetched word is held.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem_q[addr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/riscv_imem_ctrl.sv
// ============================================================================
// riscv_imem_ctrl -- instruction RAM owner: LOAD/RUN phases, loader/fetch arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_imem_ctrl
   import riscv_imem_pkg::*;
#(
   parameter int  DEPTH      = 64,
   parameter int  STARVE_MAX = 4,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld_start,
   input  logic          ld_valid,
   input  logic [31:0]   ld_addr,
   input  logic [31:0]   ld_data,
   output logic          ld_ready,
   input  logic          ld_done,
   output logic          core_hold,
   input  logic          if_req,
   input  logic [31:0]   if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,
   output logic          err_oob,
   output logic [AW:0]   ld_count
);

   localparam int          SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
   localparam logic [AW:0]   CNT_MAX    = (AW + 1)'(DEPTH);

   state_e         state_q, state_d;
   logic [SW-1:0]  starve_q, starve_d;
   logic [AW:0]    ld_count_q, ld_count_d;
   logic           err_q, err_d;
   logic           rvalid_q;
   logic           nop_sel_q;
   logic           clr_cnt;

   logic           wr_fire;
   logic           ld_oob;
   logic           if_oob;
   logic           ram_we;
   logic [AW-1:0]  ram_addr;
   logic [31:0]    ram_rdata;

   assign ld_oob  = addr_oob(ld_addr, AW);
   assign if_oob  = addr_oob(if_addr, AW);
   assign wr_fire = ld_valid && ld_ready;
   assign ram_we  = wr_fire && !ld_oob;
   // Only one requester is granted per cycle, so the port address is a simple mux.
   assign ram_addr = ram_we ? ld_addr[AW+1:2] : if_addr[AW+1:2];

   always_comb begin
      state_d   = state_q;
      starve_d  = '0;
      core_hold = 1'b1;
      ld_ready  = 1'b0;
      if_gnt    = 1'b0;
      clr_cnt   = 1'b0;
      case (state_q)
         ST_LOAD: begin
            ld_ready = 1'b1;
            if (ld_done) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            core_hold = 1'b0;
            if (ld_start) begin
               state_d = ST_LOAD;
               clr_cnt = 1'b1;
            end else begin
               // Loader has priority until fetch has waited STARVE_MAX cycles.
               if_gnt   = if_req && (!ld_valid || (starve_q == STARVE_TOP));
               ld_ready = ld_valid && !if_gnt;
               if (if_req && !if_gnt) begin
                  starve_d = starve_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_comb begin
      ld_count_d = ld_count_q;
      if (clr_cnt) begin
         ld_count_d = '0;
      end else if (ram_we && (ld_count_q != CNT_MAX)) begin
         ld_count_d = ld_count_q + 1'b1;
      end
      err_d = err_q || (wr_fire && ld_oob) || (if_gnt && if_oob);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_LOAD;
         starve_q   <= '0;
         ld_count_q <= '0;
         err_q      <= 1'b0;
         rvalid_q   <= 1'b0;
         nop_sel_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         ld_count_q <= ld_count_d;
         err_q      <= err_d;
         rvalid_q   <= if_gnt;
         if (if_gnt) begin
            nop_sel_q <= if_oob;
         end
      end
   end

   riscv_imem_sram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_sram (
      .clk   (clk),
      .we    (ram_we),
      .re    (if_gnt),
      .addr  (ram_addr),
      .wdata (ld_data),
      .rdata (ram_rdata)
   );

   assign if_rvalid = rvalid_q;
   assign if_rdata  = nop_sel_q ? NOP_INSN : ram_rdata;
   assign err_oob   = err_q;
   assign ld_count  = ld_count_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_imem_ctrl.sv
// ============================================================================
// tb_riscv_imem_ctrl -- self-checking bench with a read-data scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_riscv_imem_ctrl;

   localparam int          DEPTH      = 64;
   localparam int          STARVE_MAX = 4;
   localparam int          AW         = 6;
   localparam logic [31:0] NOP        = 32'h0000_0013;

   logic          clk;
   logic          rst_n;
   logic          ld_start;
   logic          ld_valid;
   logic [31:0]   ld_addr;
   logic [31:0]   ld_data;
   logic          ld_ready;
   logic          ld_done;
   logic          core_hold;
   logic          if_req;
   logic [31:0]   if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [31:0]   if_rdata;
   logic          err_oob;
   logic [AW:0]   ld_count;

   riscv_imem_ctrl #(
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_start  (ld_start),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .ld_done   (ld_done),
      .core_hold (core_hold),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .err_oob   (err_oob),
      .ld_count  (ld_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_total;
   int          n_bad;
   int          cyc;
   logic        mon_en;
   logic [31:0] sb_data [$];
   int          sb_cyc  [$];
   logic [31:0] mdl [DEPTH];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp_v);
      end
   endtask

   function automatic logic bad_addr(input logic [31:0] a);
      return (a[31:AW+2] != '0) || (a[1:0] != 2'b00);
   endfunction

   // Read data is due exactly one cycle after the grant it was queued for.
   always @(negedge clk) begin
      if (mon_en) begin
         logic exp_rv;
         exp_rv = (sb_cyc.size() != 0) && (sb_cyc[0] == cyc - 1);
         check_val("rvalid", 32'(if_rvalid), 32'(exp_rv));
         if (exp_rv && if_rvalid) begin
            check_val("rdata", if_rdata, sb_data[0]);
         end
         while ((sb_cyc.size() != 0) && (sb_cyc[0] < cyc)) begin
            void'(sb_cyc.pop_front());
            void'(sb_data.pop_front());
         end
      end
   end

   task automatic drive(input string tag,
                        input logic v, input logic [31:0] la, input logic [31:0] ldat,
                        input logic rq, input logic [31:0] pa,
                        input logic st, input logic dn,
                        input logic e_gnt, input logic e_rdy, input logic e_hold);
      ld_valid = v;  ld_addr = la;  ld_data = ldat;
      if_req   = rq; if_addr = pa;
      ld_start = st; ld_done = dn;
      #2;
      check_val({tag, "/gnt"},  32'(if_gnt),    32'(e_gnt));
      check_val({tag, "/rdy"},  32'(ld_ready),  32'(e_rdy));
      check_val({tag, "/hold"}, 32'(core_hold), 32'(e_hold));
      check_val({tag, "/excl"}, 32'(if_gnt & ld_ready), 32'd0);
      if (e_gnt) begin
         sb_data.push_back(bad_addr(pa) ? NOP : mdl[pa[AW+1:2]]);
         sb_cyc.push_back(cyc);
      end
      if (e_rdy && v && !bad_addr(la)) begin
         mdl[la[AW+1:2]] = ldat;
      end
      @(posedge clk);
      #1;
      ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
      if_req   = 1'b0; if_addr = '0;
      ld_start = 1'b0; ld_done = 1'b0;
   endtask

   task automatic idle(input string tag, input logic e_hold);
      drive(tag, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, e_hold, e_hold);
   endtask

   initial begin
      n_total = 0; n_bad = 0; cyc = 0; mon_en = 1'b0;
      rst_n = 1'b0;
      ld_start = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
      ld_done = 1'b0; if_req = 1'b0; if_addr = '0;

      #12;
      check_val("rst/hold",   32'(core_hold), 32'd1);
      check_val("rst/rdy",    32'(ld_ready),  32'd1);
      check_val("rst/gnt",    32'(if_gnt),    32'd0);
      check_val("rst/rvalid", 32'(if_rvalid), 32'd0);
      check_val("rst/rdata",  if_rdata,       NOP);
      check_val("rst/err",    32'(err_oob),   32'd0);
      check_val("rst/cnt",    32'(ld_count),  32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mon_en = 1'b1;

      // Boot load
      drive("w0",   1, 32'h0, 32'h4000_0113, 0, 0, 0, 0, 0, 1, 1);
      drive("w1",   1, 32'h4, 32'h8000_0437, 0, 0, 0, 0, 0, 1, 1);
      drive("done", 0, 32'h0, 32'h0,         0, 0, 0, 1, 0, 1, 1);
      check_val("boot/cnt",  32'(ld_count),  32'd2);
      check_val("boot/hold", 32'(core_hold), 32'd0);
      drive("f4",   0, 32'h0, 32'h0, 1, 32'h4, 0, 0, 1, 0, 0);
      idle("i1", 0);

      // Streaming fetch
      drive("w8", 1, 32'h8, 32'h00a0_0093, 0, 0, 0, 0, 0, 1, 0);
      drive("s0", 0, 0, 0, 1, 32'h0, 0, 0, 1, 0, 0);
      drive("s4", 0, 0, 0, 1, 32'h4, 0, 0, 1, 0, 0);
      drive("s8", 0, 0, 0, 1, 32'h8, 0, 0, 1, 0, 0);
      idle("i2", 0);

      // Contention: fetch gets through once every STARVE_MAX+1 cycles
      for (int i = 1; i <= 10; i++) begin
         logic g;
         g = (i == 5) || (i == 10);
         drive($sformatf("ct%0d", i), 1, 32'hC, 32'h1000_0000 + 32'(i), 1, 32'h0, 0, 0, g, !g, 0);
      end
      check_val("ct/cnt", 32'(ld_count), 32'd11);
      idle("i3", 0);
      drive("fC", 0, 0, 0, 1, 32'hC, 0, 0, 1, 0, 0);
      idle("i4", 0);

      // Out of range
      drive("oobw", 1, 32'h100, 32'hdead_beef, 0, 0, 0, 0, 0, 1, 0);
      check_val("oobw/cnt", 32'(ld_count), 32'd11);
      check_val("oobw/err", 32'(err_oob),  32'd1);
      drive("oobf", 0, 0, 0, 1, 32'h102, 0, 0, 1, 0, 0);
      idle("i5", 0);
      check_val("oobf/err",  32'(err_oob), 32'd1);
      check_val("oobf/hold", if_rdata,     NOP);
      drive("f0", 0, 0, 0, 1, 32'h0, 0, 0, 1, 0, 0);
      idle("i6", 0);

      // Re-entry into LOAD
      drive("rf",    0, 0, 0, 1, 32'h4, 0, 0, 1, 0, 0);
      drive("start", 1, 32'h10, 32'h1111_1111, 1, 32'h8, 1, 0, 0, 0, 0);
      check_val("re/hold", 32'(core_hold), 32'd1);
      check_val("re/cnt",  32'(ld_count),  32'd0);
      drive("ldreq", 0, 0, 0, 1, 32'h8, 0, 0, 0, 1, 1);
      drive("ldwd",  1, 32'h10, 32'h00b0_0113, 0, 0, 0, 1, 0, 1, 1);
      check_val("re/cnt1", 32'(ld_count),  32'd1);
      check_val("re/run",  32'(core_hold), 32'd0);
      drive("f10", 0, 0, 0, 1, 32'h10, 0, 0, 1, 0, 0);
      idle("i7", 0);

      // Reset during an in-flight read
      drive("rr", 0, 0, 0, 1, 32'h4, 0, 0, 1, 0, 0);
      rst_n = 1'b0;
      sb_data.delete();
      sb_cyc.delete();
      #1;
      check_val("mr/rvalid", 32'(if_rvalid), 32'd0);
      check_val("mr/rdata",  if_rdata,       NOP);
      check_val("mr/hold",   32'(core_hold), 32'd1);
      check_val("mr/cnt",    32'(ld_count),  32'd0);
      check_val("mr/err",    32'(err_oob),   32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive("d2",  0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
      drive("ret", 0, 0, 0, 1, 32'h4, 0, 0, 1, 0, 0);
      idle("i8", 0);

      check_val("sb_empty", 32'(sb_cyc.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
